// File: rtl/fas_freq_analyzer.sv
// Frequency-analysis stage: captures a 16-bin FFT frame, scans two bins per cycle
// for the largest squared magnitude, and reports the winning bin index.
module fas_freq_analyzer #(
  parameter int unsigned NBIN = 16,
  parameter int unsigned DW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fft_valid,
  input  logic [2*DW-1:0]   fft_d0,
  input  logic [2*DW-1:0]   fft_d1,
  input  logic [2*DW-1:0]   fft_d2,
  input  logic [2*DW-1:0]   fft_d3,
  input  logic [2*DW-1:0]   fft_d4,
  input  logic [2*DW-1:0]   fft_d5,
  input  logic [2*DW-1:0]   fft_d6,
  input  logic [2*DW-1:0]   fft_d7,
  input  logic [2*DW-1:0]   fft_d8,
  input  logic [2*DW-1:0]   fft_d9,
  input  logic [2*DW-1:0]   fft_d10,
  input  logic [2*DW-1:0]   fft_d11,
  input  logic [2*DW-1:0]   fft_d12,
  input  logic [2*DW-1:0]   fft_d13,
  input  logic [2*DW-1:0]   fft_d14,
  input  logic [2*DW-1:0]   fft_d15,
  output logic              done,
  output logic [3:0]        freq,
  output logic              busy,
  output logic              ovf
);

  localparam int unsigned WW = 2 * DW;
  localparam int unsigned MW = 2 * DW;
  localparam int unsigned PW = 3;
  localparam int unsigned IW = 4;
  localparam logic [PW-1:0] LAST_PAIR = PW'(7);

  typedef enum logic [0:0] {S_IDLE, S_SCAN} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_pair, w_pair_nxt;
  logic [MW-1:0]   r_best_mag, w_best_mag_nxt;
  logic [IW-1:0]   r_best_idx, w_best_idx_nxt;
  logic [IW-1:0]   r_freq, w_freq_nxt;
  logic            r_done, w_done_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            w_load;
  logic [WW-1:0]   r_bank [NBIN];
  logic [WW-1:0]   w_frame [NBIN];
  logic [MW-1:0]   w_mag0, w_mag1, w_mag_a, w_mag_b;
  logic [IW-1:0]   w_idx_a, w_idx_b;

  // Squared magnitude; each square is at most 2^30 so the 32-bit sum never wraps.
  function automatic logic [MW-1:0] sq_mag(input logic [WW-1:0] w);
    logic signed [DW-1:0] re, im;
    logic signed [MW-1:0] sre, sim;
    re  = w[WW-1:DW];
    im  = w[DW-1:0];
    sre = MW'(re) * MW'(re);
    sim = MW'(im) * MW'(im);
    return $unsigned(sre) + $unsigned(sim);
  endfunction

  assign w_frame[0]  = fft_d0;
  assign w_frame[1]  = fft_d1;
  assign w_frame[2]  = fft_d2;
  assign w_frame[3]  = fft_d3;
  assign w_frame[4]  = fft_d4;
  assign w_frame[5]  = fft_d5;
  assign w_frame[6]  = fft_d6;
  assign w_frame[7]  = fft_d7;
  assign w_frame[8]  = fft_d8;
  assign w_frame[9]  = fft_d9;
  assign w_frame[10] = fft_d10;
  assign w_frame[11] = fft_d11;
  assign w_frame[12] = fft_d12;
  assign w_frame[13] = fft_d13;
  assign w_frame[14] = fft_d14;
  assign w_frame[15] = fft_d15;

  assign w_mag0 = sq_mag(r_bank[{r_pair, 1'b0}]);
  assign w_mag1 = sq_mag(r_bank[{r_pair, 1'b1}]);

  // Even bin first, then odd bin against the updated max; strict > keeps the lower index on ties.
  always_comb begin
    w_mag_a = r_best_mag;
    w_idx_a = r_best_idx;
    if (w_mag0 > w_mag_a) begin
      w_mag_a = w_mag0;
      w_idx_a = {r_pair, 1'b0};
    end
    w_mag_b = w_mag_a;
    w_idx_b = w_idx_a;
    if (w_mag1 > w_mag_b) begin
      w_mag_b = w_mag1;
      w_idx_b = {r_pair, 1'b1};
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pair_nxt     = r_pair;
    w_best_mag_nxt = r_best_mag;
    w_best_idx_nxt = r_best_idx;
    w_freq_nxt     = r_freq;
    w_done_nxt     = 1'b0;
    w_busy_nxt     = r_busy;
    w_ovf_nxt      = r_ovf;
    w_load         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (fft_valid) begin
          w_load         = 1'b1;
          w_best_mag_nxt = '0;
          w_best_idx_nxt = '0;
          w_pair_nxt     = '0;
          w_busy_nxt     = 1'b1;
          w_state_nxt    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (fft_valid) w_ovf_nxt = 1'b1;
        w_best_mag_nxt = w_mag_b;
        w_best_idx_nxt = w_idx_b;
        w_pair_nxt     = r_pair + PW'(1);
        if (r_pair == LAST_PAIR) begin
          w_freq_nxt  = w_idx_b;
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_pair_nxt  = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pair     <= '0;
      r_best_mag <= '0;
      r_best_idx <= '0;
      r_freq     <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pair     <= w_pair_nxt;
      r_best_mag <= w_best_mag_nxt;
      r_best_idx <= w_best_idx_nxt;
      r_freq     <= w_freq_nxt;
      r_done     <= w_done_nxt;
      r_busy     <= w_busy_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  // Frame bank holds pure data and needs no reset.
  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int k = 0; k < int'(NBIN); k++) r_bank[k] <= w_frame[k];
    end
  end

  assign done = r_done;
  assign freq = r_freq;
  assign busy = r_busy;
  assign ovf  = r_ovf;

endmodule

// File: doc/fas_freq_analyzer.md
# fas_freq_analyzer

- Frequency-analysis stage of the FAS datapath. Sits directly downstream of the FFT stage.
- Captures one 16-bin FFT frame when `fft_valid` is high and computes the squared magnitude of every bin.
- Reports the index of the strongest bin on `freq`, qualified by a one-cycle `done` pulse.
- Processes two bins per cycle, so it keeps up with the FFT stage's one-frame-per-16-cycles output rate.

## Interface
Parameters:
- `NBIN`, 16, number of FFT bins per frame; fixed, since `freq` is 4 bits.
- `DW`, 16, width of each real/imag component, signed 8.8.

Ports:
- `clk`  input  1  clock; all registers are rising-edge triggered.
- `rst`  input  1  one clock; reset is asynchronous and active-high.
- `fft_valid`  input  1  `fft_d0`..`fft_d15` carry a complete frame this cycle.
- `fft_d0`..`fft_d15`  input  32 each  bin k: [31:16] real, [15:0] imag, both signed 8.8.
- `done`  output  1  one-cycle pulse; `freq` is updated in the same cycle.
- `freq`  output  4  index of the maximum-magnitude bin of the last completed frame.
- `busy`  output  1  a frame is being scanned; `fft_valid` is not accepted.
- `ovf`  output  1  sticky: a frame arrived while `busy` and was dropped.

## Operation
- States: IDLE, SCAN.
- IDLE, `fft_valid`=1:
  - Latch all 16 words into the internal frame bank.
  - Clear `best_mag` to 0, `best_idx` to 0, `pair` counter to 0.
  - Go to SCAN.
- SCAN, each cycle, process bins 2·pair and 2·pair+1:
  - mag = re·re + im·im.
  - Each square is a signed 16×16 product, non-negative, at most 2^30; the sum is 32-bit unsigned.
  - No truncation or rounding.
  - Compare order: bin 2·pair against the running max first, then bin 2·pair+1 against the updated max.
  - Replace only on strictly greater, so on ties the lowest index wins.
  - An all-zero frame reports `freq`=0.
- SCAN, pair=7: commit the final best index to `freq`, assert `done` for one cycle, go to IDLE.
- `fft_valid` while in SCAN: frame ignored, `ovf` set to 1 and held until `rst`. The scan in progress is not disturbed.
- `freq` holds its value between `done` pulses.
- Frame bank and magnitude registers are internal and are not visible at the ports.
- `rst` at any time, including mid-SCAN:
  - State goes to IDLE; the partial result is discarded.
  - No `done` is emitted for the aborted frame.

## Timing
- Reset values: `done`=0, `freq`=0, `busy`=0, `ovf`=0; internal state IDLE, `pair`=0.
- Edge E0: `fft_valid` sampled high in IDLE; frame captured; `busy`=1 after E0.
- Edges E1..E8: bin pairs 0..7 processed.
- At E8:
  - `freq` and `done` are registered.
  - `busy` falls.
  - State returns to IDLE.
- `done`=1 during the cycle between E8 and E9. Latency from capture edge to `done` is 8 cycles.
- Earliest next accepted frame is at E9, so the minimum frame spacing is 9 cycles; the FFT's 16-cycle spacing never overflows.
- `fft_valid` sampled at E1..E8 is dropped, with `ovf`=1 after that edge.
- `fft_valid` at E9 is accepted normally.
- `fft_d*` only needs to be stable at the E0 edge.

## Test plan
- Single peak: bin 0 = 0x0100_0000 (1.0+0j), others 0x0010_0010 → `done` pulse 8 cycles after capture, `freq`=0.
- Peak at bin 13 = 0x0000_FC00 (−4.0 imag), others ±0.5 → `freq`=13.
- Tie: bins 5 and 9 both 0x0200_0200, others 0 → `freq`=5. All-zero frame → `freq`=0.
- Extremes: bin 7 = 0x8000_8000, bin 6 = 0x7FFF_7FFF → `freq`=7; magnitude 2^31 without wrap.
- Back-to-back frames at E0 and E16, peaks 3 and 11:
  - Two `done` pulses, `freq`=3 then 11.
  - `ovf`=0.
  - A third frame at E4 of a scan sets `ovf`=1 and leaves that scan's result unchanged.
- Reset mid-scan: assert `rst` at E4 → `busy`=0, `done` never pulses, `freq`=0. The next frame then scans normally.
